// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad note selector: FSM states, note table, scan defaults.
// No datapath here; the helpers are pure combinational lookups.
package keypad_pkg;

    localparam int SCAN_TICKS_DEF     = 12000;
    localparam int DEBOUNCE_SLOTS_DEF = 20;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HOLD,
        RELEASE_DB
    } state_t;

    // Toggle counts for L_1..L_7, M_1..M_7, H_1, H_2, indexed by {col,row}
    localparam logic [16:0] NOTE_TABLE [16] = '{
        17'd95548, 17'd85136, 17'd75850, 17'd71582,
        17'd63776, 17'd56818, 17'd50618, 17'd47774,
        17'd42568, 17'd37919, 17'd35791, 17'd31888,
        17'd28409, 17'd25308, 17'd23889, 17'd21284
    };

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        lowest_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) lowest_low_row = 2'(i);
        end
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        col_drive = ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the asynchronous keypad rows; latency 2 clk.
// No backpressure; flops reset high so an idle (pulled-up) keypad is seen during reset.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_note_sel.sv
// 4x4 keypad scanner with press/release debounce; maps the held key to a tone half-period.
// Outputs registered, 1 clk after the deciding slot tick; no backpressure (free-running scan).
module keypad_note_sel
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = SCAN_TICKS_DEF,
    parameter int DEBOUNCE_SLOTS = DEBOUNCE_SLOTS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic [16:0] half_period,
    output logic        note_on
);

    localparam int              SW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int              DW        = $clog2(DEBOUNCE_SLOTS + 1);
    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0]   DB_LAST   = DW'(DEBOUNCE_SLOTS - 1);

    state_t        r_state;
    logic [SW-1:0] r_slot_cnt;
    logic [1:0]    r_col;
    logic [1:0]    r_row;
    logic [DW-1:0] r_db_cnt;
    logic [3:0]    r_col_out;
    logic [3:0]    r_key_code;
    logic [16:0]   r_half_period;
    logic          r_note_on;

    state_t        w_state_nxt;
    logic [3:0]    w_rows_s;
    logic          w_slot_tick;
    logic          w_any_low;
    logic          w_row_lvl;
    logic [1:0]    w_col_nxt;
    logic [1:0]    w_row_nxt;
    logic [DW-1:0] w_db_nxt;
    logic [3:0]    w_key_nxt;
    logic [16:0]   w_hp_nxt;
    logic          w_note_nxt;

    sync2 #(.WIDTH(4)) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row_in),
        .o_q   (w_rows_s)
    );

    assign w_slot_tick = (r_slot_cnt == SLOT_LAST);
    assign w_any_low   = (w_rows_s != 4'hF);
    assign w_row_lvl   = w_rows_s[r_row];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_slot_cnt <= '0;
        else if (w_slot_tick) r_slot_cnt <= '0;
        else                  r_slot_cnt <= r_slot_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SCAN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_slot_tick) begin
            case (r_state)
                SCAN:       if (w_any_low) w_state_nxt = PRESS_DB;
                PRESS_DB:   if (w_row_lvl) w_state_nxt = SCAN;
                            else if (r_db_cnt == DB_LAST) w_state_nxt = HOLD;
                HOLD:       if (w_row_lvl) w_state_nxt = RELEASE_DB;
                RELEASE_DB: if (!w_row_lvl) w_state_nxt = HOLD;
                            else if (r_db_cnt == DB_LAST) w_state_nxt = SCAN;
                default:    w_state_nxt = SCAN;
            endcase
        end
    end

    // Column stays frozen outside SCAN; a failed press resumes rotation at the next column.
    always_comb begin
        w_col_nxt  = r_col;
        w_row_nxt  = r_row;
        w_db_nxt   = r_db_cnt;
        w_key_nxt  = r_key_code;
        w_hp_nxt   = r_half_period;
        w_note_nxt = r_note_on;
        if (w_slot_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_any_low) begin
                        w_row_nxt = lowest_low_row(w_rows_s);
                        w_db_nxt  = '0;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (w_row_lvl) begin
                        w_col_nxt = r_col + 2'd1;
                    end else begin
                        w_db_nxt = r_db_cnt + 1'b1;
                        if (w_state_nxt == HOLD) begin
                            w_note_nxt = 1'b1;
                            w_key_nxt  = {r_col, r_row};
                            w_hp_nxt   = NOTE_TABLE[{r_col, r_row}];
                        end
                    end
                end
                HOLD: begin
                    if (w_row_lvl) w_db_nxt = '0;
                end
                RELEASE_DB: begin
                    if (w_row_lvl) begin
                        w_db_nxt = r_db_cnt + 1'b1;
                        if (w_state_nxt == SCAN) begin
                            w_note_nxt = 1'b0;
                            w_hp_nxt   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_db_cnt      <= '0;
            r_col_out     <= 4'b1110;
            r_key_code    <= '0;
            r_half_period <= '0;
            r_note_on     <= 1'b0;
        end else begin
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_db_cnt      <= w_db_nxt;
            r_col_out     <= col_drive(w_col_nxt);
            r_key_code    <= w_key_nxt;
            r_half_period <= w_hp_nxt;
            r_note_on     <= w_note_nxt;
        end
    end

    assign col_out     = r_col_out;
    assign key_code    = r_key_code;
    assign half_period = r_half_period;
    assign note_on     = r_note_on;

endmodule

// File: tb/tb_keypad_note_sel.sv
// Scoreboard bench: stimulus drives a keypad matrix model and queues expected output snapshots.
// The monitor pops one expectation for every change it sees on the outputs.
module tb_keypad_note_sel;

    typedef struct packed {
        logic [3:0]  col;
        logic        note;
        logic [3:0]  key;
        logic [16:0] hp;
    } snap_t;

    typedef struct packed {
        snap_t s;
        int    dt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic [16:0] half_period;
    logic        note_on;
    logic [15:0] keys = '0;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   stim_timeouts = 0;
    bit   done = 1'b0;

    keypad_note_sel #(
        .SCAN_TICKS     (10),
        .DEBOUNCE_SLOTS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .half_period (half_period),
        .note_on     (note_on)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic push(input logic [3:0] c, input logic n, input logic [3:0] k,
                        input logic [16:0] h, input int dt);
        exp_t e;
        e.s  = {c, n, k, h};
        e.dt = dt;
        exp_q.push_back(e);
    endtask

    task automatic wait_col(input logic [3:0] c);
        int n = 0;
        while (col_out == c && n < 200) begin @(negedge clk); n++; end
        while (col_out != c && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) stim_timeouts++;
    endtask

    task automatic wait_note(input logic v);
        int n = 0;
        while (note_on != v && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) stim_timeouts++;
    endtask

    initial begin
        // Reset state, then free scanning with no key
        push(4'b1110, 0, 0, 0, -1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(4'b1101, 0, 0, 0, -1);
        push(4'b1011, 0, 0, 0, 10);
        push(4'b0111, 0, 0, 0, 10);
        push(4'b1110, 0, 0, 0, 10);
        wait_col(4'b1110);

        // Key 9 (col 2, row 1) accepted after debounce
        push(4'b1101, 0, 0, 0, 10);
        push(4'b1011, 0, 0, 0, 10);
        push(4'b1011, 1, 9, 17'd37919, 40);
        wait_col(4'b1011);
        keys[9] = 1'b1;
        wait_note(1'b1);

        // Two-slot release glitch is absorbed; the true release ends the note
        push(4'b1011, 0, 9, 0, 70);
        keys[9] = 1'b0;
        repeat (20) @(negedge clk);
        keys[9] = 1'b1;
        repeat (10) @(negedge clk);
        keys[9] = 1'b0;
        wait_note(1'b0);

        // One-slot bounce returns to scanning from the next column
        push(4'b0111, 0, 9, 0, 10);
        push(4'b1110, 0, 9, 0, 10);
        push(4'b1101, 0, 9, 0, 10);
        push(4'b1011, 0, 9, 0, 10);
        push(4'b0111, 0, 9, 0, 20);
        push(4'b1110, 0, 9, 0, 10);
        wait_col(4'b1011);
        keys[9] = 1'b1;
        repeat (10) @(negedge clk);
        keys[9] = 1'b0;

        // Rows 0 and 3 of column 3 together: lowest row wins
        wait_col(4'b1110);
        keys[12] = 1'b1;
        keys[15] = 1'b1;
        push(4'b1101, 0, 9, 0, 10);
        push(4'b1011, 0, 9, 0, 10);
        push(4'b0111, 0, 9, 0, 10);
        push(4'b0111, 1, 12, 17'd28409, 40);
        wait_note(1'b1);

        // Short reset pulse mid-HOLD, not spanning a clock edge
        push(4'b1110, 0, 0, 0, -1);
        push(4'b1101, 0, 0, 0, 10);
        push(4'b1011, 0, 0, 0, 10);
        push(4'b0111, 0, 0, 0, 10);
        push(4'b1110, 0, 0, 0, 10);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        keys = '0;
        #2 rst_n = 1'b1;

        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        snap_t prev;
        snap_t cur;
        exp_t  e;
        int    cyc = 0;
        int    last = 0;
        prev = 'x;
        while (!done) begin
            @(negedge clk);
            cyc++;
            cur = {col_out, note_on, key_code, half_period};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual col=%b note=%b key=%0d hp=%0d required none",
                             cur.col, cur.note, cur.key, cur.hp);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.s || (e.dt >= 0 && (cyc - last) != e.dt)) begin
                        failures++;
                        $display("FAIL output_seq actual col=%b note=%b key=%0d hp=%0d dt=%0d required col=%b note=%b key=%0d hp=%0d dt=%0d",
                                 cur.col, cur.note, cur.key, cur.hp, cyc - last,
                                 e.s.col, e.s.note, e.s.key, e.s.hp, e.dt);
                    end
                end
                last = cyc;
                prev = cur;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        checks++;
        if (stim_timeouts != 0) begin
            failures++;
            $display("FAIL stim_wait actual=%0d required=0", stim_timeouts);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_note_sel.md
KEYPAD_NOTE_SEL -- requirements
Module: keypad_note_sel

Interface
REQ-001 SCAN_TICKS, 12000, clk cycles per column slot (1 ms at 12 MHz).
REQ-002 DEBOUNCE_SLOTS, 20, consecutive stable slots required to accept a press or a release.
REQ-003 clk  input  1  system clock, 12 MHz; single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 row_in  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive; one-hot active-low.
REQ-007 key_code  output  4  accepted key index = col*4 + row.
REQ-008 half_period  output  17  tone-generator toggle count for the held key; 0 when no note.
REQ-009 note_on  output  1  high while a debounced key is held.

Function
REQ-010 row_in SHALL pass through a 2-flop synchroniser; all logic SHALL use only the synchronised value (rows_s).
REQ-011 The slot counter SHALL count 0..SCAN_TICKS-1 and wrap; the last count is the "slot tick".
REQ-012 The FSM SHALL have four states: SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-013 SCAN: col_out SHALL rotate 1110->1101->1011->0111->1110 on each slot tick; rows_s SHALL be sampled on the slot tick before rotation.
REQ-014 SCAN: if a sample has any row low, the FSM SHALL latch the column index and the lowest-index low row, freeze col_out, clear the debounce counter, and enter PRESS_DB.
REQ-015 PRESS_DB: on each slot tick, if the latched row is still low, the debounce counter SHALL increment; otherwise the FSM SHALL return to SCAN and resume rotation from the next column.
REQ-016 PRESS_DB: when the counter reaches DEBOUNCE_SLOTS, the FSM SHALL enter HOLD; in the same cycle it SHALL set note_on=1, key_code={col,row}, and half_period=NOTE_TABLE[key_code].
REQ-017 HOLD: col_out SHALL stay frozen and outputs SHALL stay constant; if the latched row samples high on a slot tick, the FSM SHALL clear the counter and enter RELEASE_DB.
REQ-018 RELEASE_DB: on each slot tick, a high latched row SHALL increment the counter and a low latched row SHALL return the FSM to HOLD; at DEBOUNCE_SLOTS the FSM SHALL enter SCAN and set note_on=0, half_period=0, with key_code holding its last value.
REQ-019 Other keys pressed during HOLD or RELEASE_DB SHALL be ignored; there is no key rollover.
REQ-020 If several rows are low in one sample, the lowest row index SHALL win.
REQ-021 NOTE_TABLE index 0..15 SHALL be: 95548, 85136, 75850, 71582, 63776, 56818, 50618, 47774, 42568, 37919, 35791, 31888, 28409, 25308, 23889, 21284 (L_1..L_7, M_1..M_7, H_1, H_2).
REQ-022 All outputs SHALL be registered, with latency from the accepting slot tick to the output change of exactly 1 clk.

Reset
REQ-023 Asserting rst_n low SHALL immediately force: state=SCAN, col_out=4'b1110, key_code=0, half_period=0, note_on=0, and all counters and synchroniser flops cleared (synchroniser flops to 1).
REQ-024 Reset asserted mid-HOLD SHALL drop note_on in the same instant, with no release debounce.
REQ-025 After reset deassertion, scanning SHALL begin at column 0 with the slot counter at 0.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, NOTE_TABLE constants, and the default values of SCAN_TICKS and DEBOUNCE_SLOTS.
REQ-027 One sub-module, sync2 (2-flop synchroniser, 4 bits wide), SHALL be instantiated; the FSM and counters SHALL remain in keypad_note_sel.
REQ-028 half_period SHALL feed the downstream tone generator's toggle-count input directly; the tone generator SHALL gate its output with note_on.

Verification (SCAN_TICKS=10, DEBOUNCE_SLOTS=3 for simulation)
REQ-029 Reset release with no key -> col_out cycles 1110,1101,1011,0111 every 10 clk; note_on stays 0.
REQ-030 Hold row 1 low while column 2 is driven -> after 3 stable slots, note_on=1, key_code=9, half_period=37919.
REQ-031 Row bounces low for 1 slot, then goes high -> FSM returns to SCAN; note_on never rises.
REQ-032 Key 9 held; release glitch of 2 slots high, then low again -> note_on stays 1; true release of 3 slots -> note_on=0, half_period=0.
REQ-033 Rows 0 and 3 both low on column 3 -> key_code=12, half_period=28409.
REQ-034 rst_n pulsed low during HOLD -> note_on and half_period go to 0 asynchronously; col_out=1110.
